nexys_starship_monster_array: RTL and testbench

//  Parametrised multi-lane monster controller for Nexys Starship; replaces per-side monster FSMs with one block.
//  Per lane: spawn delay, random-gated spawn, attack countdown, shield kill.

---
 rtl/nexys_starship_monster_array_pkg.sv | 28 ++
 rtl/nexys_starship_monster_array_lane.sv | 94 +++++++++
 rtl/nexys_starship_monster_array.sv | 137 +++++++++++++
 tb/tb_nexys_starship_monster_array.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/nexys_starship_monster_array_pkg.sv
// Shared encodings for the Nexys Starship monster controller: global/lane states,
// level width and the per-lane status bundle handed from each lane to the top.
package nexys_starship_monster_array_pkg;

   localparam int                 LEVEL_W   = 4;
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

   // One-hot so the q_* outputs are straight decodes of the state register
   typedef enum logic [2:0] {
      G_INIT = 3'b001,
      G_PLAY = 3'b010,
      G_OVER = 3'b100
   } gstate_e;

   typedef enum logic [1:0] {
      L_EMPTY = 2'd0,
      L_ARMED = 2'd1,
      L_FULL  = 2'd2
   } lstate_e;

   typedef struct packed {
      logic req;      // armed and allowed to spawn by the LFSR bit
      logic monster;  // lane is FULL
      logic kill;     // shield destroyed the monster on this tick
      logic fail;     // sticky lane failure
   } lane_stat_t;

endpackage

// File: rtl/nexys_starship_monster_array_lane.sv
// One monster lane: EMPTY -> ARMED -> FULL cycle with saturating spawn-delay and
// attack counters; the threshold, spawn grant and run/clear come from the top.
module nexys_starship_monster_array_lane
   import nexys_starship_monster_array_pkg::*;
#(
   parameter int TIMER_W     = 8,
   parameter int SPAWN_DELAY = 1,
   parameter int THR_W       = 12
) (
   input  logic             timer_clk,
   input  logic             Reset,
   input  logic             run,
   input  logic             clear,
   input  logic             random,
   input  logic             shield,
   input  logic             grant,
   input  logic [THR_W-1:0] thr,
   output lane_stat_t       stat
);

   localparam logic [TIMER_W-1:0] SD = TIMER_W'(SPAWN_DELAY);

   lstate_e            st, st_n;
   logic [TIMER_W-1:0] dly, dly_n, d_inc;
   logic [TIMER_W-1:0] tmr, tmr_n, t_inc;
   logic               fail_q, fail_n, kill;

   assign d_inc = (&dly) ? dly : dly + 1'b1;
   assign t_inc = (&tmr) ? tmr : tmr + 1'b1;

   always_ff @(posedge timer_clk or posedge Reset) begin
      if (Reset) begin
         st     <= L_EMPTY;
         dly    <= '0;
         tmr    <= '0;
         fail_q <= 1'b0;
      end else begin
         st     <= st_n;
         dly    <= dly_n;
         tmr    <= tmr_n;
         fail_q <= fail_n;
      end
   end

   // Decisions use the incremented count so the lane reacts on the tick the
   // counter reaches its limit, not one tick later.
   always_comb begin
      st_n   = st;
      dly_n  = dly;
      tmr_n  = tmr;
      fail_n = fail_q;
      kill   = 1'b0;
      if (clear) begin
         st_n   = L_EMPTY;
         dly_n  = '0;
         tmr_n  = '0;
         fail_n = 1'b0;
      end else if (run) begin
         unique case (st)
            L_EMPTY: begin
               tmr_n = '0;
               dly_n = d_inc;
               if (d_inc >= SD) st_n = L_ARMED;
            end
            L_ARMED: begin
               if (grant) begin
                  st_n  = L_FULL;
                  tmr_n = '0;
               end
            end
            L_FULL: begin
               tmr_n = t_inc;
               if (THR_W'(t_inc) >= thr) begin
                  if (shield) begin
                     st_n  = L_EMPTY;
                     dly_n = '0;
                     tmr_n = '0;
                     kill  = 1'b1;
                  end else begin
                     fail_n = 1'b1;
                  end
               end
            end
            default: st_n = L_EMPTY;
         endcase
      end
   end

   assign stat.req     = (st == L_ARMED) && random;
   assign stat.monster = (st == L_FULL);
   assign stat.kill    = kill;
   assign stat.fail    = fail_q;

endmodule

// File: rtl/nexys_starship_monster_array.sv
// Multi-lane monster controller: global INIT/PLAY/OVER FSM, index-priority spawn
// arbiter, kill counter, difficulty level and attack threshold for all lanes.
module nexys_starship_monster_array
   import nexys_starship_monster_array_pkg::*;
#(
   parameter int NUM_LANES    = 4,
   parameter int TIMER_W      = 8,
   parameter int SPAWN_DELAY  = 1,
   parameter int ATTACK_TICKS = 12,
   parameter int ATTACK_STEP  = 2,
   parameter int MIN_ATTACK   = 4,
   parameter int LEVEL_KILLS  = 8,
   parameter int MAX_ACTIVE   = 2,
   parameter int KILL_W       = 10
) (
   input  logic                 timer_clk,
   input  logic                 Reset,
   input  logic                 play_flag,
   input  logic                 gameover_ctrl,
   input  logic [NUM_LANES-1:0] lane_random,
   input  logic [NUM_LANES-1:0] lane_shield,
   output logic                 q_init,
   output logic                 q_play,
   output logic                 q_over,
   output logic [NUM_LANES-1:0] monster,
   output logic [NUM_LANES-1:0] lane_fail,
   output logic [KILL_W-1:0]    kill_count,
   output logic [LEVEL_W-1:0]   level
);

   localparam int                THR_W = TIMER_W + 4;
   localparam int                KW1   = KILL_W + 1;
   localparam logic [KILL_W-1:0] LK    = KILL_W'(LEVEL_KILLS);

   gstate_e               g_state, g_next;
   logic                  run, clear;
   logic [NUM_LANES-1:0]  lane_req, lane_kill, grant;
   lane_stat_t            stat [NUM_LANES];
   logic [THR_W-1:0]      prod, diff, thr;
   int                    n_full, avail, given, n_kill;
   logic [KW1-1:0]        kc_sum;
   logic [KILL_W-1:0]     kc_next;
   logic                  lvl_up;

   // ---------------- global FSM ----------------
   always_ff @(posedge timer_clk or posedge Reset) begin
      if (Reset) g_state <= G_INIT;
      else       g_state <= g_next;
   end

   always_comb begin
      g_next = g_state;
      unique case (g_state)
         G_INIT:  if (play_flag)                     g_next = G_PLAY;
         G_PLAY:  if ((|lane_fail) || gameover_ctrl) g_next = G_OVER;
         G_OVER:  if (!play_flag)                    g_next = G_INIT;
         default: g_next = G_INIT;
      endcase
   end

   assign q_init = (g_state == G_INIT);
   assign q_play = (g_state == G_PLAY);
   assign q_over = (g_state == G_OVER);

   // A failed lane freezes the field on the same tick the FSM heads to OVER;
   // leaving OVER clears everything on the entry edge so INIT shows a clean slate.
   assign run   = (g_state == G_PLAY) && !(|lane_fail);
   assign clear = (g_state == G_INIT) || (g_next == G_INIT);

   // ---------------- attack threshold ----------------
   always_comb begin
      prod = THR_W'(level) * THR_W'(ATTACK_STEP);
      diff = (prod >= THR_W'(ATTACK_TICKS)) ? '0 : THR_W'(ATTACK_TICKS) - prod;
      thr  = (diff < THR_W'(MIN_ATTACK)) ? THR_W'(MIN_ATTACK) : diff;
   end

   // ---------------- spawn arbiter ----------------
   always_comb begin
      n_full = 0;
      for (int i = 0; i < NUM_LANES; i++) n_full = n_full + int'(monster[i]);
      avail = (MAX_ACTIVE > n_full) ? MAX_ACTIVE - n_full : 0;
      given = 0;
      grant = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (lane_req[i] && (given < avail)) begin
            grant[i] = 1'b1;
            given    = given + 1;
         end
      end
   end

   // ---------------- kills and level ----------------
   always_comb begin
      n_kill = 0;
      for (int i = 0; i < NUM_LANES; i++) n_kill = n_kill + int'(lane_kill[i]);
      kc_sum  = {1'b0, kill_count} + KW1'(n_kill);
      kc_next = kc_sum[KILL_W] ? '1 : kc_sum[KILL_W-1:0];
      lvl_up  = (kc_next / LK) != (kill_count / LK);
   end

   always_ff @(posedge timer_clk or posedge Reset) begin
      if (Reset) begin
         kill_count <= '0;
         level      <= '0;
      end else if (clear) begin
         kill_count <= '0;
         level      <= '0;
      end else if (run) begin
         kill_count <= kc_next;
         if (lvl_up && (level != LEVEL_MAX)) level <= level + 1'b1;
      end
   end

   // ---------------- lanes ----------------
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      nexys_starship_monster_array_lane #(
         .TIMER_W    (TIMER_W),
         .SPAWN_DELAY(SPAWN_DELAY),
         .THR_W      (THR_W)
      ) u_lane (
         .timer_clk(timer_clk),
         .Reset    (Reset),
         .run      (run),
         .clear    (clear),
         .random   (lane_random[g]),
         .shield   (lane_shield[g]),
         .grant    (grant[g]),
         .thr      (thr),
         .stat     (stat[g])
      );
      assign lane_req[g]  = stat[g].req;
      assign monster[g]   = stat[g].monster;
      assign lane_kill[g] = stat[g].kill;
      assign lane_fail[g] = stat[g].fail;
   end

endmodule

// File: tb/tb_nexys_starship_monster_array.sv
// Directed bench for the monster controller: a per-tick vector table for the
// basic game flow plus hand-written sequences for arbitration, levels and reset.
module tb_nexys_starship_monster_array;

   logic        timer_clk = 1'b0;
   logic        Reset;
   logic        play_flag, gameover_ctrl;
   logic [3:0]  lane_random, lane_shield;
   logic        q_init, q_play, q_over;
   logic [3:0]  monster, lane_fail;
   logic [9:0]  kill_count;
   logic [3:0]  level;

   int n_chk  = 0;
   int n_pass = 0;

   localparam logic [2:0] QI = 3'b001, QP = 3'b010, QO = 3'b100;

   typedef struct {
      int         n;
      logic       play, gov;
      logic [3:0] rnd, shd;
      logic [2:0] q;
      logic [3:0] mon, fail;
      int         kc, lvl;
   } vec_t;

   vec_t vecs [16];

   nexys_starship_monster_array dut (
      .timer_clk    (timer_clk),
      .Reset        (Reset),
      .play_flag    (play_flag),
      .gameover_ctrl(gameover_ctrl),
      .lane_random  (lane_random),
      .lane_shield  (lane_shield),
      .q_init       (q_init),
      .q_play       (q_play),
      .q_over       (q_over),
      .monster      (monster),
      .lane_fail    (lane_fail),
      .kill_count   (kill_count),
      .level        (level)
   );

   always #5 timer_clk = ~timer_clk;

   task automatic tick();
      @(posedge timer_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] snap();
      return {7'b0, q_over, q_play, q_init, monster, lane_fail, kill_count, level};
   endfunction

   function automatic logic [31:0] expect_of(input logic [2:0] q, input logic [3:0] mon,
                                             input logic [3:0] fail, input int kc, input int lvl);
      return {7'b0, q, mon, fail, 10'(kc), 4'(lvl)};
   endfunction

   // Waits (bounded) for monster==mask, then counts ticks until it changes.
   task automatic measure(input logic [3:0] mask, output int dur);
      int guard = 0;
      dur = 0;
      while (monster !== mask && guard < 60) begin tick(); guard++; end
      if (monster !== mask) begin dur = -1; return; end
      while (monster === mask && dur < 60) begin tick(); dur++; end
   endtask

   initial begin
      int dur, lvl, thr, guard;

      //            n  play gov  rnd   shd    q   mon   fail  kc lvl
      vecs[0]  = '{ 1, 1'b1,1'b0,4'h1, 4'h1, QP, 4'h0, 4'h0, 0, 0};
      vecs[1]  = '{ 1, 1'b1,1'b0,4'h1, 4'h1, QP, 4'h0, 4'h0, 0, 0};
      vecs[2]  = '{12, 1'b1,1'b0,4'h1, 4'h1, QP, 4'h1, 4'h0, 0, 0};
      vecs[3]  = '{ 1, 1'b1,1'b0,4'h1, 4'h1, QP, 4'h0, 4'h0, 1, 0};
      vecs[4]  = '{ 1, 1'b1,1'b0,4'h1, 4'h1, QP, 4'h0, 4'h0, 1, 0};
      vecs[5]  = '{ 1, 1'b1,1'b0,4'h1, 4'h1, QP, 4'h1, 4'h0, 1, 0};
      vecs[6]  = '{11, 1'b1,1'b0,4'h1, 4'h0, QP, 4'h1, 4'h0, 1, 0};
      vecs[7]  = '{ 1, 1'b1,1'b0,4'h1, 4'h0, QP, 4'h1, 4'h1, 1, 0};
      vecs[8]  = '{ 1, 1'b1,1'b0,4'h1, 4'h0, QO, 4'h1, 4'h1, 1, 0};
      vecs[9]  = '{ 2, 1'b1,1'b0,4'h1, 4'h0, QO, 4'h1, 4'h1, 1, 0};
      vecs[10] = '{ 1, 1'b0,1'b0,4'h1, 4'h0, QI, 4'h0, 4'h0, 0, 0};
      vecs[11] = '{ 2, 1'b0,1'b1,4'h0, 4'h0, QI, 4'h0, 4'h0, 0, 0};
      vecs[12] = '{ 1, 1'b1,1'b0,4'h0, 4'h0, QP, 4'h0, 4'h0, 0, 0};
      vecs[13] = '{ 3, 1'b0,1'b0,4'h0, 4'h0, QP, 4'h0, 4'h0, 0, 0};
      vecs[14] = '{ 1, 1'b0,1'b1,4'h0, 4'h0, QO, 4'h0, 4'h0, 0, 0};
      vecs[15] = '{ 1, 1'b0,1'b0,4'h0, 4'h0, QI, 4'h0, 4'h0, 0, 0};

      Reset = 1'b1; play_flag = 1'b0; gameover_ctrl = 1'b0;
      lane_random = '0; lane_shield = '0;
      tick(); tick();
      chk("reset", snap(), expect_of(QI, 4'h0, 4'h0, 0, 0));
      Reset = 1'b0;

      // Basic flow: spawn timing, shield kill at threshold, fail, OVER/INIT, gameover_ctrl
      for (int i = 0; i < 16; i++) begin
         play_flag = vecs[i].play; gameover_ctrl = vecs[i].gov;
         lane_random = vecs[i].rnd; lane_shield = vecs[i].shd;
         for (int t = 0; t < vecs[i].n; t++) begin
            tick();
            chk($sformatf("vec%0d.t%0d", i, t), snap(),
                expect_of(vecs[i].q, vecs[i].mon, vecs[i].fail, vecs[i].kc, vecs[i].lvl));
         end
      end

      // Arbitration: only two lanes may be FULL; lanes 2,3 wait for kills
      play_flag = 1'b1; gameover_ctrl = 1'b0; lane_random = 4'hF; lane_shield = 4'h3;
      tick(); tick(); tick();
      chk("arb_first", 32'(monster), 32'h3);
      for (int j = 1; j <= 11; j++) begin
         tick();
         chk($sformatf("arb_hold%0d", j), 32'(monster), 32'h3);
      end
      tick();
      chk("arb_kill", snap(), expect_of(QP, 4'h0, 4'h0, 2, 0));
      lane_shield = 4'h4;
      tick();
      chk("arb_next", 32'(monster), 32'hC);
      tick();
      chk("arb_denied", 32'(monster), 32'hC);
      for (int j = 0; j < 10; j++) tick();
      tick();
      chk("kill_and_fail", snap(), expect_of(QP, 4'h8, 4'h8, 3, 0));
      tick();
      chk("kill_and_fail_over", snap(), expect_of(QO, 4'h8, 4'h8, 3, 0));
      play_flag = 1'b0;
      tick();
      chk("back_to_init", snap(), expect_of(QI, 4'h0, 4'h0, 0, 0));

      // Levels: single lane, threshold shrinks 12,10,8,6,4 then floors at 4
      play_flag = 1'b1; lane_random = 4'h1; lane_shield = 4'h1;
      for (int k = 1; k <= 48; k++) begin
         lvl = (k - 1) / 8;
         thr = 12 - 2 * lvl;
         if (thr < 4) thr = 4;
         measure(4'h1, dur);
         chk($sformatf("thr_k%0d", k), 32'(dur), 32'(thr));
         chk($sformatf("kc_k%0d", k), 32'(kill_count), 32'(k));
         chk($sformatf("lvl_k%0d", k), 32'(level), 32'(k / 8));
      end
      gameover_ctrl = 1'b1; tick();
      gameover_ctrl = 1'b0; play_flag = 1'b0; tick();
      chk("lvl_game_init", snap(), expect_of(QI, 4'h0, 4'h0, 0, 0));

      // Double kill across a level boundary: 7 -> 9 bumps level once
      play_flag = 1'b1; lane_random = 4'h1; lane_shield = 4'h3;
      measure(4'h1, dur);
      chk("dbl_single", 32'(kill_count), 32'd1);
      lane_random = 4'h0; tick();
      lane_random = 4'h3;
      for (int j = 1; j <= 4; j++) begin
         measure(4'h3, dur);
         chk($sformatf("dbl_dur%0d", j), 32'(dur), 32'd12);
         chk($sformatf("dbl_kc%0d", j), 32'(kill_count), 32'(1 + 2 * j));
         chk($sformatf("dbl_lvl%0d", j), 32'(level), 32'((1 + 2 * j) / 8));
      end

      // Async reset in the middle of a FULL phase
      guard = 0;
      while (monster !== 4'h3 && guard < 40) begin tick(); guard++; end
      chk("pre_reset_full", 32'(monster), 32'h3);
      #2 Reset = 1'b1;
      #1 chk("async_reset", snap(), expect_of(QI, 4'h0, 4'h0, 0, 0));
      tick();
      Reset = 1'b0;
      tick();
      chk("post_reset_play", snap(), expect_of(QP, 4'h0, 4'h0, 0, 0));
      tick(); tick();
      chk("post_reset_spawn", 32'(monster), 32'h3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
